// File: rtl/prng_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prng_pkg
// Description : Shared definitions for the PRBS generator/checker pair:
//               feedback tap mask, generator reset seed and the checker
//               FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package prng_pkg;

    // Taps r[0], r[1], r[7], r[12], r[14], r[15], r[29], r[30].
    localparam logic [31:0] TAP_MASK = 32'h6000_D083;

    // Generator state after reset.
    localparam logic [31:0] RST_SEED = 32'h0246_8ACD;

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_CHECK = 1'b1
    } prng_state_t;

endpackage : prng_pkg
`default_nettype wire

// File: rtl/prng_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : prng_checker_if
// Description : Control, serial-bit and status signals of the PRBS checker.
//               master : source of the serial stream and control
//               slave  : the checker itself
//   clr       - synchronous restart
//   bit_valid - bit_in is sampled this cycle
//   bit_in    - received serial bit
//   locked    - checker in CHECK state
//   err_pulse - one-cycle pulse per mismatched bit
//   lock_lost - one-cycle pulse on forced resynchronisation
//   err_cnt   - saturating total mismatch count
//   bit_cnt   - wrapping count of checked bits
// Revision    : 1.0 - initial release
// ============================================================================
interface prng_checker_if;
    logic        clr;
    logic        bit_valid;
    logic        bit_in;
    logic        locked;
    logic        err_pulse;
    logic        lock_lost;
    logic [15:0] err_cnt;
    logic [31:0] bit_cnt;

    modport master (
        output clr, bit_valid, bit_in,
        input  locked, err_pulse, lock_lost, err_cnt, bit_cnt
    );

    modport slave (
        input  clr, bit_valid, bit_in,
        output locked, err_pulse, lock_lost, err_cnt, bit_cnt
    );
endinterface : prng_checker_if
`default_nettype wire

// File: rtl/prng_feedback.sv
`default_nettype none
// ============================================================================
// Module      : prng_feedback
// Description : Combinational LFSR feedback: parity of the tapped bits of a
//               32-bit state. Shared by the generator and the checker.
//   i_state - current 32-bit register contents
//   o_fb    - XOR of the bits selected by TAP_MASK
// Revision    : 1.0 - initial release
// ============================================================================
module prng_feedback
    import prng_pkg::*;
(
    input  wire logic [31:0] i_state,
    output logic             o_fb
);
    assign o_fb = ^(i_state & TAP_MASK);
endmodule : prng_feedback
`default_nettype wire

// File: rtl/prng_checker.sv
`default_nettype none
// ============================================================================
// Module      : prng_checker
// Description : Self-synchronising PRBS checker. FILL loads 32 received bits
//               into a local replica of the generator; CHECK then runs the
//               replica freely and compares every received bit against it.
//               Too many errors inside one window force a refill.
//   clk  - clock, rising edge
//   rstn - asynchronous active-low reset
//   bus  - prng_checker_if.slave (control, serial input, status outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module prng_checker
    import prng_pkg::*;
#(
    parameter int unsigned ERR_THRESH = 4,
    parameter int unsigned WIN        = 64
) (
    input  wire logic       clk,
    input  wire logic       rstn,
    prng_checker_if.slave   bus
);
    localparam int unsigned WIN_W = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int unsigned ERR_W = $clog2(ERR_THRESH + 1);
    localparam logic [WIN_W-1:0] c_WIN_LAST   = WIN_W'(WIN - 1);
    localparam logic [ERR_W-1:0] c_ERR_THRESH = ERR_W'(ERR_THRESH);

    prng_state_t       r_state,    w_state_nxt;
    logic [31:0]       r_shift,    w_shift_nxt;
    logic [4:0]        r_fill_cnt, w_fill_cnt_nxt;
    logic [WIN_W-1:0]  r_win_cnt,  w_win_cnt_nxt;
    logic [ERR_W-1:0]  r_win_err,  w_win_err_nxt;
    logic [15:0]       r_err_cnt,  w_err_cnt_nxt;
    logic [31:0]       r_bit_cnt,  w_bit_cnt_nxt;
    logic              r_locked;
    logic              r_err_pulse, w_err_pulse_nxt;
    logic              r_lock_lost, w_lock_lost_nxt;

    logic              w_pred;
    logic              w_mis;
    logic [ERR_W-1:0]  w_win_err_inc;

    prng_feedback u_feedback (
        .i_state (r_shift),
        .o_fb    (w_pred)
    );

    assign w_mis         = bus.bit_in ^ w_pred;
    // Window error count including the current bit, so an error on the last
    // bit of a window still counts toward that window's threshold.
    assign w_win_err_inc = r_win_err + ERR_W'(w_mis);

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_fill_cnt_nxt  = r_fill_cnt;
        w_win_cnt_nxt   = r_win_cnt;
        w_win_err_nxt   = r_win_err;
        w_err_cnt_nxt   = r_err_cnt;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_err_pulse_nxt = 1'b0;
        w_lock_lost_nxt = 1'b0;

        if (bus.clr) begin
            w_state_nxt    = ST_FILL;
            w_shift_nxt    = '0;
            w_fill_cnt_nxt = '0;
            w_win_cnt_nxt  = '0;
            w_win_err_nxt  = '0;
            w_err_cnt_nxt  = '0;
            w_bit_cnt_nxt  = '0;
        end else if (bus.bit_valid) begin
            if (r_state == ST_FILL) begin
                w_shift_nxt = {bus.bit_in, r_shift[31:1]};
                if (r_fill_cnt == 5'd31) begin
                    // An all-zero register is the LFSR lock-up state; refill.
                    w_fill_cnt_nxt = '0;
                    if (w_shift_nxt != 32'd0) begin
                        w_state_nxt = ST_CHECK;
                    end
                end else begin
                    w_fill_cnt_nxt = r_fill_cnt + 5'd1;
                end
            end else begin
                // Replica runs on its own prediction so a single channel
                // error cannot propagate into later comparisons.
                w_shift_nxt   = {w_pred, r_shift[31:1]};
                w_bit_cnt_nxt = r_bit_cnt + 32'd1;
                if (w_mis) begin
                    w_err_pulse_nxt = 1'b1;
                    if (r_err_cnt != 16'hFFFF) begin
                        w_err_cnt_nxt = r_err_cnt + 16'd1;
                    end
                end
                if (w_win_err_inc == c_ERR_THRESH) begin
                    w_state_nxt     = ST_FILL;
                    w_lock_lost_nxt = 1'b1;
                    w_fill_cnt_nxt  = '0;
                    w_win_cnt_nxt   = '0;
                    w_win_err_nxt   = '0;
                end else if (r_win_cnt == c_WIN_LAST) begin
                    w_win_cnt_nxt = '0;
                    w_win_err_nxt = '0;
                end else begin
                    w_win_cnt_nxt = r_win_cnt + WIN_W'(1);
                    w_win_err_nxt = w_win_err_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_FILL;
            r_shift     <= '0;
            r_fill_cnt  <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
            r_err_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_fill_cnt  <= w_fill_cnt_nxt;
            r_win_cnt   <= w_win_cnt_nxt;
            r_win_err   <= w_win_err_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_locked    <= (w_state_nxt == ST_CHECK);
            r_err_pulse <= w_err_pulse_nxt;
            r_lock_lost <= w_lock_lost_nxt;
        end
    end

    assign bus.locked    = r_locked;
    assign bus.err_pulse = r_err_pulse;
    assign bus.lock_lost = r_lock_lost;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.bit_cnt   = r_bit_cnt;

endmodule : prng_checker
`default_nettype wire

// File: tb/tb_prng_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_prng_checker
// Description : Self-checking bench for prng_checker. The reference stream
//               comes from the PRBS recurrence on a bit array; the checker
//               reference tracks the last 32 reconstructed bits in a queue
//               and counts errors per window by checked-bit index.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prng_checker;
    import prng_pkg::*;

    localparam int ERR_THRESH = 4;
    localparam int WIN        = 64;
    localparam int NBITS      = 2000;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    prng_checker_if bus ();

    prng_checker #(.ERR_THRESH(ERR_THRESH), .WIN(WIN)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- stimulus stream ----------------
    logic gen [NBITS];
    logic inv [NBITS];
    int   taps [8] = '{0, 1, 7, 12, 14, 15, 29, 30};

    task automatic build_stream();
        logic [31:0] seed;
        seed = RST_SEED;
        for (int i = 0; i < NBITS; i++) begin
            if (i < 32) gen[i] = seed[i];
            else begin
                gen[i] = 1'b0;
                foreach (taps[k]) gen[i] ^= gen[i - 32 + taps[k]];
            end
        end
    endtask

    task automatic clear_inv();
        for (int i = 0; i < NBITS; i++) inv[i] = 1'b0;
    endtask

    // ---------------- reference model ----------------
    logic        mq[$];
    logic        m_locked, m_pulse, m_lost;
    int          m_fill, m_since, m_werr, m_err;
    logic [31:0] m_bits;

    function automatic void model_clear();
        m_locked = 0; m_pulse = 0; m_lost = 0;
        m_fill = 0; m_since = 0; m_werr = 0; m_err = 0; m_bits = 0;
        mq.delete();
    endfunction

    function automatic void model_step(input logic v, input logic b, input logic c);
        logic p, nz;
        m_pulse = 0;
        m_lost  = 0;
        if (c) model_clear();
        else if (v) begin
            if (!m_locked) begin
                mq.push_back(b);
                if (mq.size() > 32) void'(mq.pop_front());
                m_fill++;
                if (m_fill == 32) begin
                    m_fill = 0;
                    nz = 0;
                    foreach (mq[k]) nz |= mq[k];
                    if (nz) begin
                        m_locked = 1; m_since = 0; m_werr = 0;
                    end
                end
            end else begin
                p = 0;
                foreach (taps[k]) p ^= mq[taps[k]];
                mq.push_back(p);
                void'(mq.pop_front());
                m_bits++;
                if (m_since % WIN == 0) m_werr = 0;
                if (b !== p) begin
                    m_pulse = 1;
                    if (m_err < 65535) m_err++;
                    m_werr++;
                end
                m_since++;
                if (m_werr == ERR_THRESH) begin
                    m_lost = 1; m_locked = 0; m_fill = 0;
                end
            end
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic drive(input logic v, input logic b, input logic c);
        bus.bit_valid = v;
        bus.bit_in    = b;
        bus.clr       = c;
        @(posedge clk);
        #1;
        model_step(v, b, c);
        check_eq("locked",    32'(bus.locked),    32'(m_locked));
        check_eq("err_pulse", 32'(bus.err_pulse), 32'(m_pulse));
        check_eq("lock_lost", 32'(bus.lock_lost), 32'(m_lost));
        check_eq("err_cnt",   32'(bus.err_cnt),   32'(m_err));
        check_eq("bit_cnt",   bus.bit_cnt,        m_bits);
        bus.bit_valid = 1'b0;
        bus.clr       = 1'b0;
    endtask

    task automatic do_reset();
        bus.bit_valid = 1'b0;
        bus.clr       = 1'b0;
        bus.bit_in    = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check_eq("rst_locked",    32'(bus.locked),    0);
        check_eq("rst_err_pulse", 32'(bus.err_pulse), 0);
        check_eq("rst_lock_lost", 32'(bus.lock_lost), 0);
        check_eq("rst_err_cnt",   32'(bus.err_cnt),   0);
        check_eq("rst_bit_cnt",   bus.bit_cnt,        0);
        model_clear();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Observations of the last run_stream call.
    int n_err_seen, n_lost_seen, first_rise, last_rise, last_lost;

    task automatic run_stream(input int start, input int n, input int gap_pct,
                              input int clr_at, input logic zeros);
        logic prev, b;
        n_err_seen = 0; n_lost_seen = 0;
        first_rise = -1; last_rise = -1; last_lost = -1;
        prev = bus.locked;
        for (int i = start; i < start + n; i++) begin
            while ($urandom_range(0, 99) < gap_pct) drive(1'b0, 1'($urandom), 1'b0);
            b = zeros ? 1'b0 : (gen[i] ^ inv[i]);
            if (i == clr_at) begin
                drive(1'b1, b, 1'b1);
                check_eq("clr_err_cnt", 32'(bus.err_cnt), 0);
                check_eq("clr_bit_cnt", bus.bit_cnt, 0);
            end else begin
                drive(1'b1, b, 1'b0);
            end
            if (bus.err_pulse) n_err_seen++;
            if (bus.lock_lost) begin n_lost_seen++; last_lost = i; end
            if (bus.locked && !prev) begin
                if (first_rise < 0) first_rise = i;
                last_rise = i;
            end
            prev = bus.locked;
        end
    endtask

    initial begin
        bus.clr = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
        build_stream();
        clear_inv();

        // Clean stream, every cycle valid.
        do_reset();
        run_stream(0, 1000, 0, -1, 1'b0);
        check_eq("clean_lock_idx", first_rise, 31);
        check_eq("clean_err_cnt",  32'(bus.err_cnt), 0);
        check_eq("clean_bit_cnt",  bus.bit_cnt, 968);
        check_eq("clean_locked",   32'(bus.locked), 1);

        // Single inverted bit.
        do_reset();
        inv[100] = 1'b1;
        run_stream(0, 1000, 0, -1, 1'b0);
        check_eq("single_pulses",  n_err_seen, 1);
        check_eq("single_err_cnt", 32'(bus.err_cnt), 1);
        check_eq("single_lost",    n_lost_seen, 0);
        check_eq("single_locked",  32'(bus.locked), 1);
        clear_inv();

        // Four errors within one window.
        do_reset();
        inv[170] = 1'b1; inv[180] = 1'b1; inv[190] = 1'b1; inv[200] = 1'b1;
        run_stream(0, 1000, 0, -1, 1'b0);
        check_eq("thresh_lost_n",   n_lost_seen, 1);
        check_eq("thresh_lost_idx", last_lost, 200);
        check_eq("thresh_relock",   last_rise, 232);
        check_eq("thresh_err_cnt",  32'(bus.err_cnt), 4);
        check_eq("thresh_bit_cnt",  bus.bit_cnt, 936);
        clear_inv();

        // Fourth error on the last bit of window 0 (checked offsets 60..63).
        do_reset();
        for (int i = 92; i <= 95; i++) inv[i] = 1'b1;
        run_stream(0, 300, 0, -1, 1'b0);
        check_eq("winlast_lost_idx", last_lost, 95);
        clear_inv();

        // Errors straddling the window boundary (offsets 61..64).
        do_reset();
        for (int i = 93; i <= 96; i++) inv[i] = 1'b1;
        run_stream(0, 300, 0, -1, 1'b0);
        check_eq("straddle_lost_n", n_lost_seen, 0);
        check_eq("straddle_err",    32'(bus.err_cnt), 4);
        clear_inv();

        // All-zero input never locks.
        do_reset();
        run_stream(0, 40, 0, -1, 1'b1);
        check_eq("zero_lock", first_rise, -1);
        check_eq("zero_locked", 32'(bus.locked), 0);

        // Random valid gaps on the clean stream.
        do_reset();
        run_stream(0, 1000, 40, -1, 1'b0);
        check_eq("gap_lock_idx", first_rise, 31);
        check_eq("gap_err_cnt",  32'(bus.err_cnt), 0);
        check_eq("gap_bit_cnt",  bus.bit_cnt, 968);

        // clr mid-CHECK; bit 400 is discarded, stream continues at 401.
        do_reset();
        run_stream(0, 600, 0, 400, 1'b0);
        check_eq("clr_relock",  last_rise, 432);
        check_eq("clr_err_end", 32'(bus.err_cnt), 0);
        check_eq("clr_bits",    bus.bit_cnt, 599 - 432);

        // Reset mid-CHECK, then stream continues.
        do_reset();
        run_stream(0, 300, 0, -1, 1'b0);
        do_reset();
        run_stream(300, 200, 0, -1, 1'b0);
        check_eq("rstmid_relock", first_rise, 331);
        check_eq("rstmid_err",    32'(bus.err_cnt), 0);

        // Random errors and gaps against the model.
        do_reset();
        for (int i = 0; i < NBITS; i++) inv[i] = ($urandom_range(0, 149) == 0);
        for (int i = 300; i < 310; i++) inv[i] = 1'b1;
        run_stream(0, NBITS, 30, -1, 1'b0);
        check_eq("rand_pulse_vs_cnt", n_err_seen, 32'(bus.err_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_prng_checker
`default_nettype wire

// File: doc/prng_checker.md
PRNG_CHECKER -- requirements
Module: prng_checker

Interface
REQ-001 Parameter ERR_THRESH, default 4, is the number of mismatches within one window that forces resynchronisation.
REQ-002 Parameter WIN, default 64, is the window length in checked bits.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 clr  input  1  synchronous restart: clears counters and forces FILL.
REQ-006 bit_valid  input  1  bit_in is sampled on this cycle.
REQ-007 bit_in  input  1  received serial bit: the generator's lfsr[0] before each shift.
REQ-008 locked  output  1  checker is in CHECK state.
REQ-009 err_pulse  output  1  one-cycle pulse per mismatched bit.
REQ-010 lock_lost  output  1  one-cycle pulse when the threshold forces resynchronisation.
REQ-011 err_cnt  output  16  total mismatches since reset or clr; saturates at 16'hFFFF.
REQ-012 bit_cnt  output  32  bits checked in CHECK since reset or clr; wraps modulo 2^32.

Function
REQ-013 Receive register r[31:0] SHALL shift on every bit_valid: r <= {new_bit, r[31:1]}.
REQ-014 Prediction p SHALL be r[0]^r[1]^r[7]^r[12]^r[14]^r[15]^r[29]^r[30], i.e. parity of r AND 32'h6000D083.
REQ-015 The FSM SHALL have two states: FILL and CHECK.
REQ-016 In FILL, new_bit = bit_in; fill counter increments 0..31 per valid bit; no compares; bit_cnt and err_cnt held.
REQ-017 On the 32nd FILL bit: if the resulting r is nonzero, go to CHECK; if r is all-zero, restart the fill counter and stay in FILL.
REQ-018 In CHECK, each valid bit SHALL be compared with p: bit_cnt+1; on mismatch, err_pulse, err_cnt+1 (saturating), window error count+1.
REQ-019 In CHECK, new_bit = p, not bit_in (free-running reference), so one channel bit error yields exactly one mismatch.
REQ-020 Window counter SHALL count checked bits; on the WIN-th bit it clears together with the window error count.
REQ-021 A mismatch on the last bit of a window SHALL count toward that window before the window is cleared.
REQ-022 When the window error count reaches ERR_THRESH, the FSM SHALL go to FILL, pulse lock_lost, and clear the fill, window and window-error counters; err_cnt and bit_cnt are kept.
REQ-023 All outputs SHALL be registered; the effect of a bit sampled in cycle n SHALL be visible in cycle n+1.
REQ-024 Cycles without bit_valid SHALL change no state, and err_pulse and lock_lost SHALL be 0 in them.
REQ-025 clr SHALL take priority over bit_valid: state FILL, all counters 0, r 0, no pulses, and the bit in that cycle discarded.

Reset
REQ-026 rstn low SHALL asynchronously set state FILL, r 0, all counters 0, and locked, err_pulse, lock_lost, err_cnt, bit_cnt all 0.
REQ-027 A reset asserted mid-CHECK SHALL abandon the lock; after release, 32 fresh bits are required before locked rises.

Structure
REQ-028 Shared package prng_pkg SHALL hold TAP_MASK 32'h6000D083, RST_SEED 32'h02468ACD and the FSM state enum.
REQ-029 Combinational sub-module prng_feedback (32-bit state in, parity of taps out) SHALL be instantiated here and reused by the generator.
REQ-030 The implementation SHALL be 120-400 lines of RTL.

Verification
REQ-031 Generator reset (seed 0x02468ACD), shift every cycle, 1000 bits -> locked rises the cycle after the 32nd bit; err_cnt 0; bit_cnt 968.
REQ-032 Same stream with bit 100 inverted -> exactly one err_pulse; err_cnt 1; locked stays 1.
REQ-033 Four inverted bits within one 64-bit window -> lock_lost pulse on the 4th; locked 0; relocks 32 valid bits later; err_cnt 4.
REQ-034 40 zero bits -> locked never asserts.
REQ-035 Random bit_valid gaps with the stream of REQ-031 -> the same results as REQ-031.
REQ-036 clr mid-CHECK, then the stream continues -> counters 0 the cycle after clr; relock after 32 bits; err_cnt 0.
